// File: rtl/dino_physics_engine.sv
// rtl/dino_physics_engine.sv - jump/fall/land physics for a side-scrolling dino sprite
module dino_physics_engine #(
  parameter int XW        = 11,
  parameter int VW        = 7,
  parameter int V_JUMP    = 32,
  parameter int G         = 4,
  parameter int G_FAST    = 12,
  parameter int V_CUT     = 8,
  parameter int V_MAXFALL = 40,
  parameter int X_DEFAULT = 50,
  parameter int Y_RESET   = 400
) (
  input  logic          FrameClk,
  input  logic          rst,
  input  logic          tick,
  input  logic          jump,
  input  logic          duck,
  input  logic          dead,
  input  logic [XW-1:0] GroundY,
  output logic [XW-1:0] Dino_X,
  output logic [XW-1:0] Dino_Y,
  output logic [VW-1:0] velocity,
  output logic [1:0]    state,
  output logic          landed
);

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    FALL   = 2'b10,
    DEAD   = 2'b11
  } state_t;

  // Constants pre-sized so every arithmetic path stays in a fixed signed width.
  localparam logic signed [VW-1:0] VJ_N   = VW'(V_JUMP);
  localparam logic signed [VW:0]   VCUT_W = (VW+1)'(V_CUT);
  localparam logic signed [VW:0]   G_W    = (VW+1)'(G);
  localparam logic signed [VW:0]   GF_W   = (VW+1)'(G_FAST);
  localparam logic signed [VW:0]   VMIN_W = -((VW+1)'(V_MAXFALL));
  localparam logic [XW-1:0]        XD     = XW'(X_DEFAULT);
  localparam logic [XW-1:0]        YR     = XW'(Y_RESET);

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [XW-1:0]         y_q, y_d;
  logic signed [VW-1:0]  v_q, v_d;
  logic                  landed_q, landed_d;

  logic signed [XW:0]    ny;
  logic signed [XW:0]    gnd_s;
  logic signed [VW:0]    vb;
  logic signed [VW:0]    geff;
  logic signed [VW:0]    vsub;
  logic signed [VW-1:0]  vn;

  // Airborne kinematics: candidate position, capped base velocity, gravity and fall-speed clamp.
  always_comb begin
    ny    = $signed({1'b0, y_q}) - $signed({{(XW+1-VW){v_q[VW-1]}}, v_q});
    gnd_s = $signed({1'b0, GroundY});
    vb    = {v_q[VW-1], v_q};
    if ((state_q == RISE) && !jump && (vb > VCUT_W)) begin
      vb = VCUT_W;
    end
    geff = duck ? GF_W : G_W;
    vsub = vb - geff;
    vn   = (vsub < VMIN_W) ? VMIN_W[VW-1:0] : vsub[VW-1:0];
  end

  // Next-state logic: dead overrides everything; otherwise ground, takeoff or airborne update.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    v_d      = v_q;
    landed_d = 1'b0;
    if (tick) begin
      if (dead) begin
        state_d = DEAD;
      end else begin
        case (state_q)
          GROUND: begin
            if (jump) begin
              v_d     = VJ_N;
              state_d = RISE;
            end else begin
              y_d = GroundY;
              v_d = '0;
            end
          end
          RISE, FALL: begin
            if (ny >= gnd_s) begin
              y_d      = GroundY;
              v_d      = '0;
              state_d  = GROUND;
              landed_d = 1'b1;
            end else if (ny[XW]) begin
              y_d     = '0;
              v_d     = '0;
              state_d = FALL;
            end else begin
              y_d     = ny[XW-1:0];
              v_d     = vn;
              state_d = (vn > 0) ? RISE : FALL;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // State and kinematic registers with asynchronous reset to the spawn point.
  always_ff @(posedge FrameClk or posedge rst) begin
    if (rst) begin
      state_q  <= GROUND;
      x_q      <= XD;
      y_q      <= YR;
      v_q      <= '0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      v_q      <= v_d;
      landed_q <= landed_d;
    end
  end

  assign Dino_X   = x_q;
  assign Dino_Y   = y_q;
  assign velocity = v_q;
  assign state    = state_q;
  assign landed   = landed_q;

endmodule
